slbi_arb: RTL and testbench

SLBI_ARB -- requirements
Module: slbi_arb

---
 rtl/slbi_arb_if.sv | 21 ++
 rtl/slbi_arb.sv | 70 +++++++
 tb/tb_slbi_arb.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/slbi_arb_if.sv
// Bundle of requester and shared-slbi-unit signals around slbi_arb.
// slave is the arbiter side, master is the requester/unit side.
interface slbi_arb_if #(parameter int WIDTH = 16);
  logic             req0, req1;
  logic [WIDTH-1:0] in1_0, in1_1;
  logic [7:0]       imm0, imm1;
  logic [WIDTH-1:0] slbi_in1, slbi_in2, slbi_out;
  logic             gnt0, gnt1, done0, done1;
  logic [WIDTH-1:0] result;
  logic             busy;

  modport slave (
    input  req0, in1_0, imm0, req1, in1_1, imm1, slbi_out,
    output slbi_in1, slbi_in2, gnt0, gnt1, done0, done1, result, busy
  );

  modport master (
    output req0, in1_0, imm0, req1, in1_1, imm1, slbi_out,
    input  slbi_in1, slbi_in2, gnt0, gnt1, done0, done1, result, busy
  );
endinterface

// File: rtl/slbi_arb.sv
// Two-requester round-robin arbiter for one shared combinational slbi unit.
// Fixed three-cycle turn: sample in IDLE, drive unit in ISSUE, pulse done in RESP.
module slbi_arb #(
  parameter int WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  slbi_arb_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t           r_state, w_next;
  logic             r_owner, r_last;
  logic [WIDTH-1:0] r_op1, r_result;
  logic [7:0]       r_imm;
  logic             w_any, w_win;

  // Both requesting: the one not served last wins; otherwise the lone requester.
  always_comb begin
    w_any = bus.req0 | bus.req1;
    w_win = (bus.req0 & bus.req1) ? ~r_last : bus.req1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next = ISSUE;
      ISSUE:   w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner  <= 1'b0;
      r_last   <= 1'b1;
      r_op1    <= '0;
      r_imm    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_any) begin
          r_owner <= w_win;
          r_op1   <= w_win ? bus.in1_1 : bus.in1_0;
          r_imm   <= w_win ? bus.imm1  : bus.imm0;
        end
        ISSUE:   r_result <= bus.slbi_out;
        RESP:    r_last   <= r_owner;
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.slbi_in1 = (r_state == ISSUE) ? r_op1 : '0;
    bus.slbi_in2 = (r_state == ISSUE) ? {{(WIDTH-8){1'b0}}, r_imm} : '0;
    bus.gnt0     = (r_state == ISSUE) & ~r_owner;
    bus.gnt1     = (r_state == ISSUE) &  r_owner;
    bus.done0    = (r_state == RESP)  & ~r_owner;
    bus.done1    = (r_state == RESP)  &  r_owner;
    bus.result   = r_result;
    bus.busy     = (r_state != IDLE);
  end
endmodule

// File: tb/tb_slbi_arb.sv
// Bench for slbi_arb: transaction-level schedule model checked every cycle,
// plus directed scenarios with hand-computed literals.
module tb_slbi_arb;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  slbi_arb_if #(.WIDTH(W)) bus ();
  slbi_arb #(.WIDTH(W)) u_dut (.clk(clk), .rst(rst), .bus(bus.slave));

  // Shared unit: shift left by 8 and insert the immediate.
  assign bus.slbi_out = (bus.slbi_in1 << 8) | bus.slbi_in2;

  int n_chk  = 0;
  int n_fail = 0;
  int done_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: edges numbered from reset release; an op sampled at edge t owns
  // the unit between edges t and t+1, signals done between t+1 and t+2,
  // and the next sample can happen no earlier than edge t+3.
  int          n       = 0;
  int          t       = -100;
  int          free_at = 0;
  int          last    = 1;
  int          m_own   = 0;
  logic [W-1:0] m_op   = '0;
  logic [7:0]   m_imm  = '0;
  logic [W-1:0] m_res  = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      n = 0; t = -100; free_at = 0; last = 1; m_res = '0; m_own = 0;
    end else begin
      n = n + 1;
      if (n == t + 1) begin
        m_res = {m_op[7:0], m_imm};
        last  = m_own;
      end
      if (n >= free_at && (bus.req0 || bus.req1)) begin
        if (bus.req0 && bus.req1) m_own = (last == 0) ? 1 : 0;
        else                      m_own = bus.req1 ? 1 : 0;
        m_op    = (m_own == 1) ? bus.in1_1 : bus.in1_0;
        m_imm   = (m_own == 1) ? bus.imm1  : bus.imm0;
        t       = n;
        free_at = n + 3;
      end
    end
  end

  always @(negedge clk) begin
    logic iss, rsp;
    iss = (n == t);
    rsp = (n == t + 1);
    check("gnt0",     32'(bus.gnt0),     32'(iss && m_own == 0));
    check("gnt1",     32'(bus.gnt1),     32'(iss && m_own == 1));
    check("done0",    32'(bus.done0),    32'(rsp && m_own == 0));
    check("done1",    32'(bus.done1),    32'(rsp && m_own == 1));
    check("busy",     32'(bus.busy),     32'(iss || rsp));
    check("slbi_in1", 32'(bus.slbi_in1), iss ? 32'(m_op) : 32'd0);
    check("slbi_in2", 32'(bus.slbi_in2), iss ? 32'(m_imm) : 32'd0);
    check("result",   32'(bus.result),   32'(m_res));
    check("onehot",   32'($countones({bus.gnt0, bus.gnt1, bus.done0, bus.done1}) <= 1), 32'd1);
    if (bus.done0) done_log.push_back(0);
    if (bus.done1) done_log.push_back(1);
  end

  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cyc(2);
    rst = 1'b1;
  endtask

  initial begin
    int base;
    bus.req0 = 0; bus.req1 = 0;
    bus.in1_0 = '0; bus.in1_1 = '0; bus.imm0 = '0; bus.imm1 = '0;

    // Reset state
    cyc(3);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_busy",   32'(bus.busy),   32'd0);
    rst = 1'b1;

    // Single request
    bus.req0 = 1; bus.in1_0 = 16'h1234; bus.imm0 = 8'hAB;
    cyc(1);
    check("single_gnt0", 32'(bus.gnt0),     32'd1);
    check("single_in2",  32'(bus.slbi_in2), 32'h00AB);
    bus.req0 = 0;
    cyc(1);
    check("single_done0",  32'(bus.done0),  32'd1);
    check("single_result", 32'(bus.result), 32'h34AB);
    cyc(1);
    check("single_gnt_off", 32'(bus.gnt0), 32'd0);

    // Simultaneous requests after reset: 0,1,0,1
    do_reset();
    base = done_log.size();
    bus.req0 = 1; bus.in1_0 = 16'h0102; bus.imm0 = 8'h10;
    bus.req1 = 1; bus.in1_1 = 16'h0304; bus.imm1 = 8'h20;
    cyc(12);
    bus.req0 = 0; bus.req1 = 0;
    cyc(2);
    check("rr_count", 32'(done_log.size()), 32'(base + 4));
    if (done_log.size() >= base + 4) begin
      check("rr_0", 32'(done_log[base+0]), 32'd0);
      check("rr_1", 32'(done_log[base+1]), 32'd1);
      check("rr_2", 32'(done_log[base+2]), 32'd0);
      check("rr_3", 32'(done_log[base+3]), 32'd1);
    end

    // Operand stability
    bus.req1 = 1; bus.in1_1 = 16'h00FF; bus.imm1 = 8'h01;
    cyc(1);
    bus.in1_1 = 16'hAAAA; bus.imm1 = 8'h55; bus.req1 = 0;
    cyc(1);
    check("stab_done1",  32'(bus.done1),  32'd1);
    check("stab_result", 32'(bus.result), 32'hFF01);
    cyc(2);

    // Withdrawn request
    base = done_log.size();
    bus.req1 = 1;
    cyc(1);
    bus.req1 = 0;
    cyc(6);
    check("wd_count", 32'(done_log.size()), 32'(base + 1));
    if (done_log.size() > base) check("wd_owner", 32'(done_log[base]), 32'd1);

    // Reset mid-operation
    bus.req0 = 1; bus.in1_0 = 16'h5678; bus.imm0 = 8'h9A;
    cyc(1);
    check("mid_gnt0_pre", 32'(bus.gnt0), 32'd1);
    base = done_log.size();
    rst = 1'b0;
    #1;
    check("mid_gnt0",   32'(bus.gnt0),     32'd0);
    check("mid_busy",   32'(bus.busy),     32'd0);
    check("mid_result", 32'(bus.result),   32'd0);
    check("mid_in1",    32'(bus.slbi_in1), 32'd0);
    bus.req0 = 0;
    cyc(2);
    check("mid_nodone", 32'(done_log.size()), 32'(base));
    rst = 1'b1;
    bus.req0 = 1; bus.req1 = 1;
    cyc(1);
    check("mid_first0", 32'(bus.gnt0), 32'd1);
    bus.req0 = 0; bus.req1 = 0;
    cyc(3);

    // Random stress
    for (int i = 0; i < 200; i++) begin
      bus.req0  = ($urandom_range(0, 99) < 55);
      bus.req1  = ($urandom_range(0, 99) < 55);
      bus.in1_0 = W'($urandom);
      bus.in1_1 = W'($urandom);
      bus.imm0  = 8'($urandom);
      bus.imm1  = 8'($urandom);
      cyc(1);
    end
    bus.req0 = 0; bus.req1 = 0;
    cyc(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout at %0t: got running expected finished", $time);
    $fatal(1);
  end
endmodule
